// File: rtl/cve2_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package cve2_pkg;

    localparam int WportDepthDefault = 2;
    // Buffered write data is held at full register width; narrower DataWidth builds use the low bits.
    localparam int WportDataW = 32;

    typedef struct packed {
        logic [4:0]            waddr;
        logic [WportDataW-1:0] wdata;
        logic                  valid;
    } wport_req_t;

endpackage

// File: rtl/cve2_wport_fifo.sv
// Circular buffer of deferred execute writes with kill-by-address and read-address match.
// CVE2_WPORT_FWD_EN adds forwarding data outputs for the youngest matching entry.
module cve2_wport_fifo
    import cve2_pkg::*;
#(
    parameter int DEPTH = WportDepthDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  wport_req_t              push_req_i,
    input  logic                    pop_i,
    input  logic                    kill_i,
    input  logic [4:0]              kill_addr_i,
    output wport_req_t              head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    input  logic [4:0]              rs1_addr_i,
    input  logic [4:0]              rs2_addr_i,
    output logic                    rs1_hit_o,
`ifdef CVE2_WPORT_FWD_EN
    output logic [WportDataW-1:0]   rs1_data_o,
    output logic [WportDataW-1:0]   rs2_data_o,
`endif
    output logic                    rs2_hit_o
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    wport_req_t        mem [DEPTH];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [CntW-1:0]   count;
    logic [PtrW-1:0]   idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else begin
            // A load to the same register is younger, so older buffered writes must never land.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && mem[i].valid && (mem[i].waddr == kill_addr_i)) mem[i].valid <= 1'b0;
            end
            if (pop_i) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            // Pushing after popping lets a full buffer recycle the head slot in one cycle.
            if (push_i) begin
                mem[wr_ptr] <= push_req_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            count <= count + CntW'(push_i) - CntW'(pop_i);
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

    // Walk oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        rs1_hit_o = 1'b0;
        rs2_hit_o = 1'b0;
`ifdef CVE2_WPORT_FWD_EN
        rs1_data_o = '0;
        rs2_data_o = '0;
`endif
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PtrW'(i);
            if ((CntW'(i) < count) && mem[idx].valid) begin
                if ((rs1_addr_i != 5'd0) && (mem[idx].waddr == rs1_addr_i)) begin
                    rs1_hit_o = 1'b1;
`ifdef CVE2_WPORT_FWD_EN
                    rs1_data_o = mem[idx].wdata;
`endif
                end
                if ((rs2_addr_i != 5'd0) && (mem[idx].waddr == rs2_addr_i)) begin
                    rs2_hit_o = 1'b1;
`ifdef CVE2_WPORT_FWD_EN
                    rs2_data_o = mem[idx].wdata;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/cve2_rf_wport_arb.sv
// Single register-file write port shared by non-stallable load responses and buffered execute results.
// CVE2_WPORT_FWD_EN exposes forwarding of buffered data and suppresses the hazard outputs.
module cve2_rf_wport_arb
    import cve2_pkg::*;
#(
    parameter int DEPTH     = WportDepthDefault,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_we_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic                 lsu_err_i,
    input  logic                 flush_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic                 rs1_hazard_o,
    output logic                 rs2_hazard_o,
`ifdef CVE2_WPORT_FWD_EN
    output logic                 rs1_fwd_o,
    output logic                 rs2_fwd_o,
    output logic [DataWidth-1:0] rs1_fwd_data_o,
    output logic [DataWidth-1:0] rs2_fwd_data_o,
`endif
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 pend_o
);

    localparam int CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic            lsu_act;
    logic            drain_slot;
    logic            buf_empty;
    logic            ex_acc;
    logic            pass_thru;
    logic            push;
    logic            pop;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [CntW-1:0] count;
    wport_req_t      push_req;
    wport_req_t      head;
`ifdef CVE2_WPORT_FWD_EN
    logic [WportDataW-1:0] rs1_data;
    logic [WportDataW-1:0] rs2_data;
`endif

    assign lsu_act    = lsu_we_i & ~lsu_err_i & (lsu_waddr_i != 5'd0);
    assign drain_slot = ~lsu_act & ~flush_i;
    assign buf_empty  = (count == '0);
    assign ex_ready_o = (count < DepthC) | ~lsu_act;
    assign ex_acc     = ex_we_i & ex_ready_o & (ex_waddr_i != 5'd0) & ~flush_i;
    assign pass_thru  = ex_acc & buf_empty & drain_slot;
    assign push       = ex_acc & ~pass_thru;
    assign pop        = ~buf_empty & drain_slot;
    assign pend_o     = ~buf_empty;

    assign push_req.waddr = ex_waddr_i;
    assign push_req.wdata = WportDataW'(ex_wdata_i);
    assign push_req.valid = 1'b1;

    cve2_wport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_req_i  (push_req),
        .pop_i       (pop),
        .kill_i      (lsu_act),
        .kill_addr_i (lsu_waddr_i),
        .head_o      (head),
        .count_o     (count),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_hit_o   (rs1_hit),
`ifdef CVE2_WPORT_FWD_EN
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
`endif
        .rs2_hit_o   (rs2_hit)
    );

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = '0;
        if (lsu_act) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (pass_thru) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end else if (pop && head.valid) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head.waddr;
            rf_wdata_o = head.wdata[DataWidth-1:0];
        end
    end

`ifdef CVE2_WPORT_FWD_EN
    assign rs1_fwd_o      = rs1_hit;
    assign rs2_fwd_o      = rs2_hit;
    assign rs1_fwd_data_o = rs1_data[DataWidth-1:0];
    assign rs2_fwd_data_o = rs2_data[DataWidth-1:0];
    assign rs1_hazard_o   = 1'b0;
    assign rs2_hazard_o   = 1'b0;
`else
    assign rs1_hazard_o   = rs1_hit;
    assign rs2_hazard_o   = rs2_hit;
`endif

endmodule

// File: tb/tb_cve2_rf_wport_arb.sv
// Directed self-checking bench for cve2_rf_wport_arb (default build, DEPTH=2).
module tb_cve2_rf_wport_arb;

    logic        clk_i;
    logic        rst_ni;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        lsu_we_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_err_i;
    logic        flush_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_hazard_o;
    logic        rs2_hazard_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        pend_o;

    int n_cmp;
    int n_fail;

    cve2_rf_wport_arb #(
        .DEPTH     (2),
        .DataWidth (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_we_i      (ex_we_i),
        .ex_waddr_i   (ex_waddr_i),
        .ex_wdata_i   (ex_wdata_i),
        .ex_ready_o   (ex_ready_o),
        .lsu_we_i     (lsu_we_i),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_err_i    (lsu_err_i),
        .flush_i      (flush_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_hazard_o (rs1_hazard_o),
        .rs2_hazard_o (rs2_hazard_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .pend_o       (pend_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        chk1({tag, ".we"}, rf_we_o, we);
        chk32({tag, ".waddr"}, 32'(rf_waddr_o), 32'(wa));
        chk32({tag, ".wdata"}, rf_wdata_o, wd);
    endtask

    task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic lw, input logic [4:0] la, input logic [31:0] ld,
                         input logic le, input logic fl);
        ex_we_i     = ew;
        ex_waddr_i  = ea;
        ex_wdata_i  = ed;
        lsu_we_i    = lw;
        lsu_waddr_i = la;
        lsu_wdata_i = ld;
        lsu_err_i   = le;
        flush_i     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        idle();
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd5;
        #3;
        chk1("rst.pend", pend_o, 1'b0);
        chk1("rst.ready", ex_ready_o, 1'b1);
        chk1("rst.hz1", rs1_hazard_o, 1'b0);
        chk1("rst.hz2", rs2_hazard_o, 1'b0);
        chk1("rst.we", rf_we_o, 1'b0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // empty buffer: same-cycle pass-through
        drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #3;
        chk_rf("pass", 1'b1, 5'd5, 32'hA5);
        chk1("pass.pend", pend_o, 1'b0);
        cyc();
        idle();
        #3;
        chk1("pass.pend_after", pend_o, 1'b0);
        cyc();

        // write to x0 is accepted and dropped
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #3;
        chk1("x0.we", rf_we_o, 1'b0);
        chk1("x0.ready", ex_ready_o, 1'b1);
        cyc();
        idle();
        #3;
        chk1("x0.pend", pend_o, 1'b0);
        cyc();

        // load to x0 is not active, so EX passes through
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'h33, 1'b0, 1'b0);
        #3;
        chk_rf("lsu_x0", 1'b1, 5'd9, 32'h99);
        cyc();

        // simultaneous lsu x3 and ex x4
        drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
        #3;
        chk_rf("coll.c0", 1'b1, 5'd3, 32'h11);
        chk1("coll.c0.pend", pend_o, 1'b0);
        cyc();
        idle();
        rs1_addr_i = 5'd4;
        #3;
        chk_rf("coll.c1", 1'b1, 5'd4, 32'h22);
        chk1("coll.c1.pend", pend_o, 1'b1);
        chk1("coll.c1.hz1", rs1_hazard_o, 1'b1);
        cyc();
        #3;
        chk_rf("coll.c2", 1'b0, 5'd0, 32'h0);
        chk1("coll.c2.pend", pend_o, 1'b0);
        chk1("coll.c2.hz1", rs1_hazard_o, 1'b0);
        cyc();

        // sustained load pressure fills the buffer
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd10, 32'h100, 1'b0, 1'b0);
        #3;
        chk1("full.c0.ready", ex_ready_o, 1'b1);
        chk_rf("full.c0", 1'b1, 5'd10, 32'h100);
        cyc();
        drive(1'b1, 5'd21, 32'h210, 1'b1, 5'd11, 32'h110, 1'b0, 1'b0);
        #3;
        chk1("full.c1.ready", ex_ready_o, 1'b1);
        chk1("full.c1.pend", pend_o, 1'b1);
        cyc();
        drive(1'b1, 5'd22, 32'h220, 1'b1, 5'd12, 32'h120, 1'b0, 1'b0);
        #3;
        chk1("full.c2.ready", ex_ready_o, 1'b0);
        chk_rf("full.c2", 1'b1, 5'd12, 32'h120);
        cyc();
        drive(1'b1, 5'd22, 32'h220, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #3;
        chk1("full.c3.ready", ex_ready_o, 1'b1);
        chk_rf("full.c3", 1'b1, 5'd20, 32'h200);
        cyc();
        idle();
        #3;
        chk_rf("full.c4", 1'b1, 5'd21, 32'h210);
        chk1("full.c4.pend", pend_o, 1'b1);
        cyc();
        #3;
        chk_rf("full.c5", 1'b1, 5'd22, 32'h220);
        cyc();
        #3;
        chk1("full.c6.pend", pend_o, 1'b0);
        chk1("full.c6.we", rf_we_o, 1'b0);
        cyc();

        // buffered x7 killed by a later load to x7
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd1, 32'h01, 1'b0, 1'b0);
        #3;
        chk32("kill.c0.waddr", 32'(rf_waddr_o), 32'd1);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h99, 1'b0, 1'b0);
        rs1_addr_i = 5'd7;
        #3;
        chk_rf("kill.c1", 1'b1, 5'd7, 32'h99);
        chk1("kill.c1.hz1", rs1_hazard_o, 1'b1);
        cyc();
        idle();
        #3;
        chk1("kill.c2.we", rf_we_o, 1'b0);
        chk1("kill.c2.pend", pend_o, 1'b1);
        chk1("kill.c2.hz1", rs1_hazard_o, 1'b0);
        cyc();
        #3;
        chk1("kill.c3.pend", pend_o, 1'b0);
        cyc();

        // two buffered entries discarded by flush
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd2, 32'h02, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd9, 32'h98, 1'b1, 5'd2, 32'h03, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        rs1_addr_i = 5'd8;
        rs2_addr_i = 5'd9;
        #3;
        chk1("flush.c0.hz1", rs1_hazard_o, 1'b1);
        chk1("flush.c0.hz2", rs2_hazard_o, 1'b1);
        chk1("flush.c0.pend", pend_o, 1'b1);
        chk1("flush.c0.we", rf_we_o, 1'b0);
        cyc();
        idle();
        #3;
        chk1("flush.c1.pend", pend_o, 1'b0);
        chk1("flush.c1.we", rf_we_o, 1'b0);
        chk1("flush.c1.hz1", rs1_hazard_o, 1'b0);
        chk1("flush.c1.hz2", rs2_hazard_o, 1'b0);
        chk1("flush.c1.ready", ex_ready_o, 1'b1);
        cyc();
        #3;
        chk1("flush.c2.we", rf_we_o, 1'b0);
        cyc();

        // load error suppresses the load write; head drains instead
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd1, 32'h01, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hFF, 1'b1, 1'b0);
        #3;
        chk_rf("lerr.c1", 1'b1, 5'd6, 32'h66);
        chk1("lerr.c1.pend", pend_o, 1'b1);
        cyc();
        idle();
        #3;
        chk1("lerr.c2.pend", pend_o, 1'b0);
        chk1("lerr.c2.we", rf_we_o, 1'b0);
        cyc();

        // reset mid-operation discards the buffer immediately
        drive(1'b1, 5'd14, 32'hE0, 1'b1, 5'd1, 32'h01, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h02, 1'b0, 1'b0);
        rs1_addr_i = 5'd14;
        #3;
        chk1("mrst.pre.hz1", rs1_hazard_o, 1'b1);
        chk1("mrst.pre.pend", pend_o, 1'b1);
        rst_ni = 1'b0;
        idle();
        #1;
        chk1("mrst.pend", pend_o, 1'b0);
        chk1("mrst.hz1", rs1_hazard_o, 1'b0);
        chk1("mrst.we", rf_we_o, 1'b0);
        chk1("mrst.ready", ex_ready_o, 1'b1);
        cyc();
        rst_ni = 1'b1;
        cyc();
        #3;
        chk1("mrst.post.we", rf_we_o, 1'b0);
        chk1("mrst.post.pend", pend_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cve2_rf_wport_arb.md
CVE2_RF_WPORT_ARB -- requirements
Module: cve2_rf_wport_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning execute-write buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter DataWidth, default 32, meaning register data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low (clk_i, rst_ni).
REQ-004 SHALL have port clk_i  in  1  core clock.
REQ-005 SHALL have port rst_ni  in  1  async active-low reset.
REQ-006 SHALL have port ex_we_i  in  1  execute result write request.
REQ-007 SHALL have port ex_waddr_i  in  5  execute destination register.
REQ-008 SHALL have port ex_wdata_i  in  DataWidth  execute result.
REQ-009 SHALL have port ex_ready_o  out  1  execute request accepted this cycle.
REQ-010 SHALL have port lsu_we_i  in  1  load response write (cannot stall).
REQ-011 SHALL have port lsu_waddr_i  in  5  load destination register.
REQ-012 SHALL have port lsu_wdata_i  in  DataWidth  load data.
REQ-013 SHALL have port lsu_err_i  in  1  load error; suppresses the load write.
REQ-014 SHALL have port flush_i  in  1  discard all buffered writes.
REQ-015 SHALL have port rs1_addr_i, rs2_addr_i  in  5 each  decode read addresses.
REQ-016 SHALL have port rs1_hazard_o, rs2_hazard_o  out  1 each  read address matches a buffered entry.
REQ-017 SHALL have port rf_we_o, rf_waddr_o, rf_wdata_o  out  1/5/DataWidth  single register-file write port.
REQ-018 SHALL have port pend_o  out  1  buffer non-empty.

Function
REQ-019 SHALL define lsu_act = lsu_we_i & ~lsu_err_i & (lsu_waddr_i != 0); lsu_act always wins the write port, with zero latency.
REQ-020 SHALL, when the buffer is empty, ~lsu_act and ~flush_i, pass an accepted EX write through combinationally with zero latency.
REQ-021 SHALL otherwise enqueue an accepted EX write at the tail, and drain the head on any cycle where ~lsu_act and ~flush_i.
REQ-022 SHALL retire EX writes strictly in acceptance order; head/tail pointers wrap modulo DEPTH.
REQ-023 SHALL drive ex_ready_o = (count < DEPTH) | ~lsu_act; when full with no LSU write, dequeue and enqueue occur in the same cycle.
REQ-024 SHALL accept but drop EX writes to x0, with no enqueue and no rf_we_o.
REQ-025 SHALL kill (invalidate in place) any buffered entry whose address equals lsu_waddr_i when lsu_act, because the load result is architecturally younger; killed entries drain without asserting rf_we_o.
REQ-026 SHALL, on flush_i, clear count and pointers next edge, not assert rf_we_o for buffered entries, drop a concurrent EX request, and still perform lsu_act.
REQ-027 SHALL assert rsN_hazard_o combinationally when rsN_addr_i != 0 and it matches any valid buffered entry.
REQ-028 SHALL drive rf_waddr_o and rf_wdata_o as 0 whenever rf_we_o is 0.

Reset
REQ-029 SHALL, under reset, set count, pointers and valid bits to 0, so that pend_o=0, ex_ready_o=1 and hazards=0.
REQ-030 SHALL, when reset is asserted mid-operation, discard buffered entries immediately with no register-file write.

Configuration
REQ-031 SHALL implement macro CVE2_WPORT_FWD_EN: when defined, adds outputs rs1_fwd_o/rs2_fwd_o (1) and rs1_fwd_data_o/rs2_fwd_data_o (DataWidth) giving the youngest matching valid buffered data, and forces rsN_hazard_o to 0; when undefined, these ports are absent and hazards behave per REQ-027.

Structure
REQ-032 SHALL take typedef wport_req_t {waddr, wdata, valid} and the constant WportDepthDefault=2 from cve2_pkg.
REQ-033 SHALL place the circular buffer, including the kill-by-address and match logic, in sub-module cve2_wport_fifo.

Verification
REQ-034 SHALL cover: empty buffer, ex_we_i with x5=0xA5 -> same-cycle rf_we_o=1, waddr=5, wdata=0xA5, pend_o=0.
REQ-035 SHALL cover: lsu x3=0x11 and ex x4=0x22 simultaneously -> cycle0 writes x3, cycle1 writes x4; pend_o=1 only in cycle1.
REQ-036 SHALL cover: lsu_act held 3 cycles with EX every cycle, DEPTH=2 -> ex_ready_o=0 in cycle2; drains x-order preserved afterward.
REQ-037 SHALL cover: buffered x7 then lsu x7 -> x7 holds load data, and the buffered x7 produces no write.
REQ-038 SHALL cover: two buffered entries plus flush_i -> no rf_we_o next cycles, pend_o=0, rs hazards clear.
REQ-039 SHALL cover: lsu_err_i=1 with lsu_we_i=1 -> no load write, and the buffer head drains that cycle.
